cic_interpolate: RTL and testbench
==================================

// Module: cic_interpolate
// PURPOSE
//  Multichannel rate expander for the CIC interpolator. It is the inverse of the decimate stage.
//  - Accepts one sample per channel at the low rate.
//  - Emits R samples per input at CLK rate: the sample, then R-1 zeros (zero-stuff).
//  - Sits between the comb section (upstream) and the integrator section (downstream).
//  - Channels are time-multiplexed and tagged by ChIdx, up to 16 channels.
// PARAMETERS
//  MIDDLE_WIDTH           37  data width in and out
//  CIC_MAX_CHANNELS       16  number of channel tags supported (ChIdx is 4 bits)
//  CIC_MAX_ICEF           16  largest allowed interpolation factor R
//  CIC_ICEF_DEFAULT       16  R after reset
//  CIC_CONFIG_DATA_WIDTH  16  width of Data_Config_In
// PORTS
//  CLK             in   1   clock; all logic on posedge
//  nRST            in   1   reset, asynchronous, active-low
//  isConfig        in   1   one-cycle request to load a new R
//  isConfigDone    out  1   one-cycle pulse when the new R has been loaded
//  Data_Config_In  in   CIC_CONFIG_DATA_WIDTH   new R value
//  Data_In         in   MIDDLE_WIDTH  signed input sample
//  Data_In_Valid   in   1   input sample valid
//  Data_In_ChIdx   in   4   channel tag of the input sample
//  Data_In_Ready   out  1   block can accept an input sample
//  Data_Out        out  MIDDLE_WIDTH  signed output sample
//  Data_Out_Valid  out  1   output sample valid
//  Data_Out_ChIdx  out  4   channel tag of the output sample
// BEHAVIOUR
//  Reset values
//  - All outputs are 0, except Data_In_Ready = 1.
//  - Internal state after reset: R = CIC_ICEF_DEFAULT, buffer empty, config FSM in IDLE.
//  Input handshake
//  - A sample is accepted on a posedge where Data_In_Valid && Data_In_Ready.
//  - The sample and its ChIdx are written into a 2-entry FIFO.
//  - Data_In_Ready = (count < 2) && (config FSM in IDLE or RUN). It is a registered-count decode.
//  Burst generation
//  - When the FIFO is non-empty, the head entry starts a burst of R_b cycles.
//  - R_b is the value of R latched at burst start.
//  - A phase counter runs 0..R_b-1.
//  - Phase 0: Data_Out = sample. Phases 1..R_b-1: Data_Out = 0.
//  - Data_Out_Valid = 1 in every phase. Data_Out_ChIdx = the entry's tag in every phase.
//  - On the last phase the head entry is popped.
//  - The next burst starts on the following cycle with no bubble.
//  Latency and wrap-around
//  - Phase 0 appears on the posedge after the accepting edge when the FIFO was empty.
//  - The phase counter wraps to 0 at R_b-1.
//  - R_b = 1 means pass-through: one output per input.
//  Simultaneous push and pop
//  - Push and pop in the same cycle are allowed; count is unchanged.
//  - A push is never accepted while full, because Ready is low.
//  Output when idle
//  - When the FIFO is empty, Data_Out_Valid = 0.
//  - Data_Out and Data_Out_ChIdx hold their last values.
//  Arithmetic
//  - No arithmetic on data. Data is passed through bit-exact.
//  - Gain compensation is done downstream.
//  Reset mid-burst
//  - nRST low clears the FIFO, the phase counter and R immediately, regardless of state.
// CONFIGURATION
//  Config FSM: IDLE -> LOAD -> DONE -> RUN
//  - IDLE: waits for isConfig.
//  - LOAD: captures Data_Config_In. A value of 0 becomes 1; a value above CIC_MAX_ICEF becomes CIC_MAX_ICEF.
//  - DONE: isConfigDone = 1 for exactly one cycle.
//  - RUN: returns to LOAD on the next isConfig.
//  Data_In_Ready is 0 during LOAD and DONE.
//  A burst in progress finishes with its latched R_b. The new R applies from the next burst start.
//  isConfig is ignored while in LOAD or DONE.
//  Optional feature, macro CIC_INTERP_HOLD_EN
//  - Defined: sample-and-hold. Phases 1..R_b-1 repeat the sample instead of 0.
//  - Not defined: zero-stuff as described above.
// TESTING
//  1. Reset, R=16; push 37'h1 on ch3 -> 16 valid cycles: 1,0x15; ChIdx=3; Valid falls after the 16th.
//  2. Config 4, then push ch0=5, ch1=7 back-to-back -> 5,0,0,0 (ch0) then 7,0,0,0 (ch1); no gap; isConfigDone one cycle.
//  3. R=4, Valid held high with 6 samples -> Ready drops after 2 accepted; all 6 bursts appear in order; no sample lost.
//  4. Config 0 -> pass-through (R=1); config 40 -> R=16; push a sample during LOAD -> not accepted (Ready=0).
//  5. Issue isConfig(2) during phase 1 of an R=4 burst -> that burst completes 4 phases; the next burst is 2 phases.
//  6. Build with CIC_INTERP_HOLD_EN, R=3, push -9 -> -9,-9,-9. Assert nRST mid-burst -> Valid=0 and Ready=1 at once.

Source files
------------

// File: rtl/cic_interpolate.sv
// cic_interpolate: multichannel rate expander for the CIC interpolator (zero-stuff by R per input sample).
// Optional macro CIC_INTERP_HOLD_EN: sample-and-hold, so every phase of a burst repeats the sample.
`timescale 1ns/1ps
module cic_interpolate #(
    parameter int MIDDLE_WIDTH          = 37,
    parameter int CIC_MAX_CHANNELS      = 16,
    parameter int CIC_MAX_ICEF          = 16,
    parameter int CIC_ICEF_DEFAULT      = 16,
    parameter int CIC_CONFIG_DATA_WIDTH = 16
) (
    input  logic                                    CLK,
    input  logic                                    nRST,
    input  logic                                    isConfig,
    output logic                                    isConfigDone,
    input  logic        [CIC_CONFIG_DATA_WIDTH-1:0] Data_Config_In,
    input  logic signed [MIDDLE_WIDTH-1:0]          Data_In,
    input  logic                                    Data_In_Valid,
    input  logic        [$clog2(CIC_MAX_CHANNELS)-1:0] Data_In_ChIdx,
    output logic                                    Data_In_Ready,
    output logic signed [MIDDLE_WIDTH-1:0]          Data_Out,
    output logic                                    Data_Out_Valid,
    output logic        [$clog2(CIC_MAX_CHANNELS)-1:0] Data_Out_ChIdx
);

    localparam int CHW = $clog2(CIC_MAX_CHANNELS);
    localparam int RW  = $clog2(CIC_MAX_ICEF + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_RUN} cfg_state_t;

    // A requested factor of 0 is meaningless, so it is treated as pass-through.
    function automatic logic [RW-1:0] clamp_icef(input logic [CIC_CONFIG_DATA_WIDTH-1:0] v);
        if (v == '0)
            return RW'(1);
        else if (v > CIC_CONFIG_DATA_WIDTH'(CIC_MAX_ICEF))
            return RW'(CIC_MAX_ICEF);
        else
            return v[RW-1:0];
    endfunction

    cfg_state_t r_state;
    cfg_state_t w_state_nxt;
    logic       w_cfg_load;
    logic       w_cfg_open;

    logic [RW-1:0] r_icef;
    logic [RW-1:0] r_rb;
    logic [RW-1:0] r_phase;
    logic [RW-1:0] w_rb;
    logic          w_last;

    logic signed [MIDDLE_WIDTH-1:0] r_fifo_data [2];
    logic        [CHW-1:0]          r_fifo_tag  [2];
    logic                           r_wr_ptr;
    logic                           r_rd_ptr;
    logic [1:0]                     r_count;
    logic                           w_push;
    logic                           w_pop;
    logic                           w_busy;
    logic signed [MIDDLE_WIDTH-1:0] w_head_data;
    logic        [CHW-1:0]          w_head_tag;
    logic signed [MIDDLE_WIDTH-1:0] w_beat;

    // Configuration FSM
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cfg_load  = 1'b0;
        w_cfg_open  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cfg_open = 1'b1;
                if (isConfig)
                    w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_cfg_load  = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: w_state_nxt = S_RUN;
            S_RUN: begin
                w_cfg_open = 1'b1;
                if (isConfig)
                    w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign isConfigDone = (r_state == S_DONE);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_icef <= RW'(CIC_ICEF_DEFAULT);
        else if (w_cfg_load)
            r_icef <= clamp_icef(Data_Config_In);
    end

    // Two-entry input buffer
    assign Data_In_Ready = (r_count < 2'd2) && w_cfg_open;
    assign w_push        = Data_In_Valid && Data_In_Ready;
    assign w_busy        = (r_count != 2'd0);
    assign w_head_data   = r_fifo_data[r_rd_ptr];
    assign w_head_tag    = r_fifo_tag[r_rd_ptr];

    // Phase 0 latches the current factor; later phases keep the burst's own copy.
    assign w_rb   = (r_phase == '0) ? r_icef : r_rb;
    assign w_last = (r_phase == (w_rb - RW'(1)));
    assign w_pop  = w_busy && w_last;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= Data_In;
            r_fifo_tag[r_wr_ptr]  <= Data_In_ChIdx;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push)
                r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Burst phase counter
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_phase <= '0;
            r_rb    <= RW'(CIC_ICEF_DEFAULT);
        end else if (w_busy) begin
            r_rb    <= w_rb;
            r_phase <= w_last ? '0 : r_phase + RW'(1);
        end
    end

`ifdef CIC_INTERP_HOLD_EN
    assign w_beat = w_head_data;
`else
    assign w_beat = (r_phase == '0) ? w_head_data : '0;
`endif

    // Output register; data and tag hold their last values while idle
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            Data_Out       <= '0;
            Data_Out_Valid <= 1'b0;
            Data_Out_ChIdx <= '0;
        end else begin
            Data_Out_Valid <= w_busy;
            if (w_busy) begin
                Data_Out       <= w_beat;
                Data_Out_ChIdx <= w_head_tag;
            end
        end
    end

endmodule

// File: tb/tb_cic_interpolate.sv
// Testbench for cic_interpolate: randomized samples checked against a burst-expansion queue model.
`timescale 1ns/1ps
module tb_cic_interpolate;

    localparam int DW = 37;

    logic                 CLK = 1'b0;
    logic                 nRST;
    logic                 isConfig;
    logic                 isConfigDone;
    logic [15:0]          Data_Config_In;
    logic signed [DW-1:0] Data_In;
    logic                 Data_In_Valid;
    logic [3:0]           Data_In_ChIdx;
    logic                 Data_In_Ready;
    logic signed [DW-1:0] Data_Out;
    logic                 Data_Out_Valid;
    logic [3:0]           Data_Out_ChIdx;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [3:0]    t;
    } beat_t;

    beat_t exp_q[$];

    always #5 CLK = ~CLK;

    cic_interpolate dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .isConfig       (isConfig),
        .isConfigDone   (isConfigDone),
        .Data_Config_In (Data_Config_In),
        .Data_In        (Data_In),
        .Data_In_Valid  (Data_In_Valid),
        .Data_In_ChIdx  (Data_In_ChIdx),
        .Data_In_Ready  (Data_In_Ready),
        .Data_Out       (Data_Out),
        .Data_Out_Valid (Data_Out_Valid),
        .Data_Out_ChIdx (Data_Out_ChIdx)
    );

    // Reference: one accepted sample expands into r output beats with its tag.
    function automatic void expect_burst(input logic [DW-1:0] d, input logic [3:0] t, input int r);
        for (int i = 0; i < r; i++) begin
            beat_t b;
`ifdef CIC_INTERP_HOLD_EN
            b.d = d;
`else
            b.d = (i == 0) ? d : '0;
`endif
            b.t = t;
            exp_q.push_back(b);
        end
    endfunction

    function automatic logic [DW-1:0] rnd_sample();
        logic [63:0] x;
        x = {$urandom, $urandom};
        return x[DW-1:0];
    endfunction

    task automatic apply_config(input logic [15:0] v);
        @(negedge CLK);
        isConfig = 1'b1;
        Data_Config_In = v;
        @(negedge CLK);
        isConfig = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        #12;
        total++; if (Data_Out_Valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", Data_Out_Valid); end
        total++; if (Data_Out !== '0) begin bad++; $display("FAIL reset_data: got %0h want 0", Data_Out); end
        total++; if (Data_Out_ChIdx !== 4'd0) begin bad++; $display("FAIL reset_chidx: got %0d want 0", Data_Out_ChIdx); end
        total++; if (isConfigDone !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", isConfigDone); end
        total++; if (Data_In_Ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", Data_In_Ready); end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_default_r16();
        beat_t e;
        int nval = 0, first = -1, last = -1;
        for (int c = 0; c < 22; c++) begin
            @(negedge CLK);
            if (Data_Out_Valid) begin
                nval++; if (first < 0) first = c; last = c;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL r16_beat: unexpected beat %0h ch%0d", Data_Out, Data_Out_ChIdx); end
                else begin
                    e = exp_q.pop_front();
                    if ({Data_Out, Data_Out_ChIdx} !== {e.d, e.t}) begin bad++; $display("FAIL r16_beat: got %0h ch%0d want %0h ch%0d", Data_Out, Data_Out_ChIdx, e.d, e.t); end
                end
            end
            Data_In_Valid = (c == 0); Data_In = 37'sd1; Data_In_ChIdx = 4'd3;
            if (Data_In_Valid && Data_In_Ready) expect_burst(37'd1, 4'd3, 16);
        end
        Data_In_Valid = 1'b0;
        total++; if (first != 2) begin bad++; $display("FAIL r16_latency: first beat at cycle %0d want 2", first); end
        total++; if (nval != 16 || last - first != 15) begin bad++; $display("FAIL r16_count: got %0d beats span %0d want 16", nval, last - first + 1); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL r16_drain: %0d beats missing want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_config_b2b();
        beat_t e;
        int nval = 0, first = -1, last = -1;
        @(negedge CLK); isConfig = 1'b1; Data_Config_In = 16'd4;
        @(negedge CLK); isConfig = 1'b0;
        total++; if (Data_In_Ready !== 1'b0) begin bad++; $display("FAIL cfg_load_ready: got %b want 0", Data_In_Ready); end
        total++; if (isConfigDone !== 1'b0) begin bad++; $display("FAIL cfg_load_done: got %b want 0", isConfigDone); end
        @(negedge CLK);
        total++; if (isConfigDone !== 1'b1) begin bad++; $display("FAIL cfg_done_pulse: got %b want 1", isConfigDone); end
        total++; if (Data_In_Ready !== 1'b0) begin bad++; $display("FAIL cfg_done_ready: got %b want 0", Data_In_Ready); end
        @(negedge CLK);
        total++; if (isConfigDone !== 1'b0) begin bad++; $display("FAIL cfg_done_width: got %b want 0", isConfigDone); end
        total++; if (Data_In_Ready !== 1'b1) begin bad++; $display("FAIL cfg_run_ready: got %b want 1", Data_In_Ready); end
        for (int c = 0; c < 14; c++) begin
            @(negedge CLK);
            if (Data_Out_Valid) begin
                nval++; if (first < 0) first = c; last = c;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_beat: unexpected beat %0h ch%0d", Data_Out, Data_Out_ChIdx); end
                else begin
                    e = exp_q.pop_front();
                    if ({Data_Out, Data_Out_ChIdx} !== {e.d, e.t}) begin bad++; $display("FAIL b2b_beat: got %0h ch%0d want %0h ch%0d", Data_Out, Data_Out_ChIdx, e.d, e.t); end
                end
            end
            Data_In_Valid = (c < 2);
            Data_In = (c == 0) ? 37'sd5 : 37'sd7;
            Data_In_ChIdx = (c == 0) ? 4'd0 : 4'd1;
            if (Data_In_Valid && Data_In_Ready) expect_burst(Data_In, Data_In_ChIdx, 4);
        end
        Data_In_Valid = 1'b0;
        total++; if (nval != 8 || last - first != 7) begin bad++; $display("FAIL b2b_gapless: got %0d beats span %0d want 8", nval, last - first + 1); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain: %0d beats missing want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_backpressure();
        beat_t e;
        logic [DW-1:0] smp [6];
        logic [3:0]    tg  [6];
        int nval = 0, first = -1, last = -1, sent = 0;
        for (int i = 0; i < 6; i++) begin smp[i] = rnd_sample(); tg[i] = 4'($urandom_range(0, 15)); end
        apply_config(16'd4);
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (Data_Out_Valid) begin
                nval++; if (first < 0) first = c; last = c;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL bp_beat: unexpected beat %0h ch%0d", Data_Out, Data_Out_ChIdx); end
                else begin
                    e = exp_q.pop_front();
                    if ({Data_Out, Data_Out_ChIdx} !== {e.d, e.t}) begin bad++; $display("FAIL bp_beat: got %0h ch%0d want %0h ch%0d", Data_Out, Data_Out_ChIdx, e.d, e.t); end
                end
            end
            if (c < 3) begin
                total++;
                if (Data_In_Ready !== (c < 2)) begin bad++; $display("FAIL bp_ready: cycle %0d got %b want %b", c, Data_In_Ready, (c < 2)); end
            end
            Data_In_Valid = (sent < 6);
            if (sent < 6) begin Data_In = smp[sent]; Data_In_ChIdx = tg[sent]; end
            if (Data_In_Valid && Data_In_Ready) begin expect_burst(Data_In, Data_In_ChIdx, 4); sent++; end
        end
        Data_In_Valid = 1'b0;
        total++; if (sent != 6) begin bad++; $display("FAIL bp_accepted: got %0d want 6", sent); end
        total++; if (nval != 24 || last - first != 23) begin bad++; $display("FAIL bp_stream: got %0d beats span %0d want 24", nval, last - first + 1); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_drain: %0d beats missing want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_clamp();
        beat_t e;
        int nval = 0, first = -1, last = -1;
        apply_config(16'd0);
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (Data_Out_Valid) begin
                nval++; if (first < 0) first = c; last = c;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL r1_beat: unexpected beat %0h ch%0d", Data_Out, Data_Out_ChIdx); end
                else begin
                    e = exp_q.pop_front();
                    if ({Data_Out, Data_Out_ChIdx} !== {e.d, e.t}) begin bad++; $display("FAIL r1_beat: got %0h ch%0d want %0h ch%0d", Data_Out, Data_Out_ChIdx, e.d, e.t); end
                end
            end
            Data_In_Valid = (c < 3); Data_In = rnd_sample(); Data_In_ChIdx = 4'($urandom_range(0, 15));
            if (Data_In_Valid && Data_In_Ready) expect_burst(Data_In, Data_In_ChIdx, 1);
        end
        Data_In_Valid = 1'b0;
        total++; if (nval != 3 || first != 2 || last != 4) begin bad++; $display("FAIL r1_passthru: got %0d beats at %0d..%0d want 3 at 2..4", nval, first, last); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL r1_drain: %0d beats missing want 0", exp_q.size()); exp_q.delete(); end

        @(negedge CLK); isConfig = 1'b1; Data_Config_In = 16'd40;
        @(negedge CLK); isConfig = 1'b0;
        total++; if (Data_In_Ready !== 1'b0) begin bad++; $display("FAIL load_ready: got %b want 0", Data_In_Ready); end
        Data_In_Valid = 1'b1; Data_In = rnd_sample(); Data_In_ChIdx = 4'd9;
        @(negedge CLK);
        total++; if (Data_In_Ready !== 1'b0) begin bad++; $display("FAIL done_ready: got %b want 0", Data_In_Ready); end
        @(negedge CLK);
        Data_In_Valid = 1'b0;

        nval = 0;
        for (int c = 0; c < 22; c++) begin
            @(negedge CLK);
            if (Data_Out_Valid) begin
                nval++;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL r40_beat: unexpected beat %0h ch%0d", Data_Out, Data_Out_ChIdx); end
                else begin
                    e = exp_q.pop_front();
                    if ({Data_Out, Data_Out_ChIdx} !== {e.d, e.t}) begin bad++; $display("FAIL r40_beat: got %0h ch%0d want %0h ch%0d", Data_Out, Data_Out_ChIdx, e.d, e.t); end
                end
            end
            Data_In_Valid = (c == 0); Data_In = rnd_sample(); Data_In_ChIdx = 4'd12;
            if (Data_In_Valid && Data_In_Ready) expect_burst(Data_In, Data_In_ChIdx, 16);
        end
        Data_In_Valid = 1'b0;
        total++; if (nval != 16) begin bad++; $display("FAIL r40_clamp: got %0d beats want 16", nval); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL r40_drain: %0d beats missing want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_midburst_config();
        beat_t e;
        int nval = 0, first = -1, last = -1;
        apply_config(16'd4);
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            if (Data_Out_Valid) begin
                nval++; if (first < 0) first = c; last = c;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL mid_beat: unexpected beat %0h ch%0d", Data_Out, Data_Out_ChIdx); end
                else begin
                    e = exp_q.pop_front();
                    if ({Data_Out, Data_Out_ChIdx} !== {e.d, e.t}) begin bad++; $display("FAIL mid_beat: got %0h ch%0d want %0h ch%0d", Data_Out, Data_Out_ChIdx, e.d, e.t); end
                end
            end
            isConfig = (c == 3);
            if (c == 3) Data_Config_In = 16'd2;
            Data_In_Valid = (c < 2); Data_In = rnd_sample(); Data_In_ChIdx = 4'($urandom_range(0, 15));
            if (Data_In_Valid && Data_In_Ready) expect_burst(Data_In, Data_In_ChIdx, (c == 0) ? 4 : 2);
        end
        Data_In_Valid = 1'b0;
        total++; if (nval != 6 || last - first != 5) begin bad++; $display("FAIL mid_lengths: got %0d beats span %0d want 6", nval, last - first + 1); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL mid_drain: %0d beats missing want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_hold_and_reset();
        beat_t e;
        int nval = 0;
        apply_config(16'd3);
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (Data_Out_Valid) begin
                nval++;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL r3_beat: unexpected beat %0h ch%0d", Data_Out, Data_Out_ChIdx); end
                else begin
                    e = exp_q.pop_front();
                    if ({Data_Out, Data_Out_ChIdx} !== {e.d, e.t}) begin bad++; $display("FAIL r3_beat: got %0h ch%0d want %0h ch%0d", Data_Out, Data_Out_ChIdx, e.d, e.t); end
                end
            end
            Data_In_Valid = (c == 0); Data_In = -37'sd9; Data_In_ChIdx = 4'($urandom_range(0, 15));
            if (Data_In_Valid && Data_In_Ready) expect_burst(Data_In, Data_In_ChIdx, 3);
        end
        total++; if (nval != 3 || exp_q.size() != 0) begin bad++; $display("FAIL r3_count: got %0d beats, %0d missing, want 3 and 0", nval, exp_q.size()); exp_q.delete(); end

        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            Data_In_Valid = (c == 0); Data_In = rnd_sample(); Data_In_ChIdx = 4'd6;
        end
        #2 nRST = 1'b0;
        #1;
        total++; if (Data_Out_Valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", Data_Out_Valid); end
        total++; if (Data_In_Ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: got %b want 1", Data_In_Ready); end
        total++; if (Data_Out !== '0) begin bad++; $display("FAIL rst_mid_data: got %0h want 0", Data_Out); end
        exp_q.delete();
        @(negedge CLK);
        nRST = 1'b1;

        nval = 0;
        for (int c = 0; c < 22; c++) begin
            @(negedge CLK);
            if (Data_Out_Valid) begin
                nval++;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL post_rst_beat: unexpected beat %0h ch%0d", Data_Out, Data_Out_ChIdx); end
                else begin
                    e = exp_q.pop_front();
                    if ({Data_Out, Data_Out_ChIdx} !== {e.d, e.t}) begin bad++; $display("FAIL post_rst_beat: got %0h ch%0d want %0h ch%0d", Data_Out, Data_Out_ChIdx, e.d, e.t); end
                end
            end
            Data_In_Valid = (c == 0); Data_In = rnd_sample(); Data_In_ChIdx = 4'd2;
            if (Data_In_Valid && Data_In_Ready) expect_burst(Data_In, Data_In_ChIdx, 16);
        end
        Data_In_Valid = 1'b0;
        total++; if (nval != 16 || exp_q.size() != 0) begin bad++; $display("FAIL post_rst_r16: got %0d beats, %0d missing, want 16 and 0", nval, exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        nRST = 1'b0;
        isConfig = 1'b0;
        Data_Config_In = '0;
        Data_In = '0;
        Data_In_Valid = 1'b0;
        Data_In_ChIdx = '0;
        test_reset();
        test_default_r16();
        test_config_b2b();
        test_backpressure();
        test_clamp();
        test_midburst_config();
        test_hold_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
